// File: rtl/dm_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds the FSM/owner encodings and the latched access payload.
package dm_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_req_t;

    // DM is word-addressed: byte offset bits are forced to zero
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, EXT and DM signal bundle around the arbiter.
// master = the arbiter itself, slave = the requesters and the memory.
interface dm_arbiter_if;
    import dm_arbiter_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [BE_W-1:0]   cpu_be;
    logic              cpu_stall;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [BE_W-1:0]   ext_be;
    logic              ext_done;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_stall, cpu_done, cpu_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_be,
        output ext_done, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_stall, cpu_done, cpu_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_be,
        input  ext_done, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin pick between CPU (req[0]) and EXT (req[1]).
// On a tie the port that did not own the previous access wins.
module dm_arbiter_rr_arb2
    import dm_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    output logic       grant_c,
    output owner_e     winner_c
);

    always_comb begin
        grant_c  = |req;
        winner_c = OWN_CPU;
        if (req == 2'b11) begin
            winner_c = (last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
        end else if (req[1]) begin
            winner_c = OWN_EXT;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the MEM stage and an EXT requester,
// running each access for MEM_LAT cycles and stalling the pipeline meanwhile.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 2
) (
    input logic          clk,
    input logic          reset,
    dm_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e           state;
    owner_e           owner;
    owner_e           last_owner;
    logic [CNT_W-1:0] cnt;
    logic             grant_c;
    owner_e           winner_c;
    mem_req_t         pick_c;

    dm_arbiter_rr_arb2 u_rr (
        .req        ({bus.ext_req, bus.cpu_req}),
        .last_owner (last_owner),
        .grant_c    (grant_c),
        .winner_c   (winner_c)
    );

    // Payload of whichever port the arbiter would grant this cycle
    always_comb begin
        pick_c = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata, be: bus.cpu_be};
        if (winner_c == OWN_EXT) begin
            pick_c = '{we: bus.ext_we, addr: bus.ext_addr, wdata: bus.ext_wdata, be: bus.ext_be};
        end
    end

    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= OWN_CPU;
            last_owner    <= OWN_EXT;
            cnt           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.cpu_rdata <= '0;
            bus.ext_rdata <= '0;
            bus.cpu_done  <= 1'b0;
            bus.ext_done  <= 1'b0;
        end else begin
            bus.cpu_done <= 1'b0;
            bus.ext_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= pick_c.we;
                        bus.mem_addr  <= word_addr(pick_c.addr);
                        bus.mem_wdata <= pick_c.wdata;
                        bus.mem_be    <= pick_c.be;
                        owner         <= winner_c;
                        last_owner    <= winner_c;
                        cnt           <= CNT_LOAD;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    // Final access cycle: read data is valid, hand it to the owner
                    if (cnt == '0) begin
                        if (owner == OWN_CPU) begin
                            bus.cpu_rdata <= bus.mem_rdata;
                            bus.cpu_done  <= 1'b1;
                        end else begin
                            bus.ext_rdata <= bus.mem_rdata;
                            bus.ext_done  <= 1'b1;
                        end
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: two instances (MEM_LAT 2 and 4) share one stimulus stream
// and are checked every cycle against an access-timeline model.
module tb_dm_arbiter;

    localparam int LAT0 = 2;
    localparam int LAT1 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [3:0]  cpu_be, ext_be;
    logic        mem_init;

    dm_arbiter_if if0 ();
    dm_arbiter_if if1 ();

    assign if0.cpu_req = cpu_req;   assign if1.cpu_req = cpu_req;
    assign if0.cpu_we = cpu_we;     assign if1.cpu_we = cpu_we;
    assign if0.cpu_addr = cpu_addr; assign if1.cpu_addr = cpu_addr;
    assign if0.cpu_wdata = cpu_wdata; assign if1.cpu_wdata = cpu_wdata;
    assign if0.cpu_be = cpu_be;     assign if1.cpu_be = cpu_be;
    assign if0.ext_req = ext_req;   assign if1.ext_req = ext_req;
    assign if0.ext_we = ext_we;     assign if1.ext_we = ext_we;
    assign if0.ext_addr = ext_addr; assign if1.ext_addr = ext_addr;
    assign if0.ext_wdata = ext_wdata; assign if1.ext_wdata = ext_wdata;
    assign if0.ext_be = ext_be;     assign if1.ext_be = ext_be;

    dm_arbiter #(.MEM_LAT(LAT0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    dm_arbiter #(.MEM_LAT(LAT1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'hDEAD_BEEF : ((32'h0101_0101 * 32'(i)) ^ 32'hA5A5_0000);
    endfunction

    // Data memories seen by each instance: 256 words indexed by addr[9:2]
    logic [31:0] dm0 [256];
    logic [31:0] dm1 [256];
    assign if0.mem_rdata = dm0[if0.mem_addr[9:2]];
    assign if1.mem_rdata = dm1[if1.mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                dm0[i] <= init_word(i);
                dm1[i] <= init_word(i);
            end
        end else begin
            if (if0.mem_en && if0.mem_we)
                dm0[if0.mem_addr[9:2]] <= merge(dm0[if0.mem_addr[9:2]], if0.mem_wdata, if0.mem_be);
            if (if1.mem_en && if1.mem_we)
                dm1[if1.mem_addr[9:2]] <= merge(dm1[if1.mem_addr[9:2]], if1.mem_wdata, if1.mem_be);
        end
    end

    int n_checks, n_errors, cyc;
    bit armed;

    // Reference model: one outstanding access per instance, described by its grant cycle
    bit          g_valid [2];
    int          g_cycle [2];
    int          free_at [2];
    bit          g_own   [2];
    bit          last_own[2];
    logic        g_we    [2];
    logic [31:0] g_addr  [2];
    logic [31:0] g_wdata [2];
    logic [3:0]  g_be    [2];
    logic [31:0] exp_crd [2];
    logic [31:0] exp_erd [2];
    logic [31:0] ref_mem [2][256];
    bit          m_cd0;

    logic        o_en [2], o_we [2], o_cd [2], o_ed [2], o_st [2];
    logic [31:0] o_addr [2], o_wdata [2], o_crd [2], o_erd [2];
    logic [3:0]  o_be [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, expv);
        end
    endtask

    task automatic sample(input int k);
        if (k == 0) begin
            o_en[0] = if0.mem_en; o_we[0] = if0.mem_we; o_addr[0] = if0.mem_addr;
            o_wdata[0] = if0.mem_wdata; o_be[0] = if0.mem_be; o_cd[0] = if0.cpu_done;
            o_ed[0] = if0.ext_done; o_st[0] = if0.cpu_stall; o_crd[0] = if0.cpu_rdata;
            o_erd[0] = if0.ext_rdata;
        end else begin
            o_en[1] = if1.mem_en; o_we[1] = if1.mem_we; o_addr[1] = if1.mem_addr;
            o_wdata[1] = if1.mem_wdata; o_be[1] = if1.mem_be; o_cd[1] = if1.cpu_done;
            o_ed[1] = if1.ext_done; o_st[1] = if1.cpu_stall; o_crd[1] = if1.cpu_rdata;
            o_erd[1] = if1.ext_rdata;
        end
    endtask

    task automatic model_step(input int k);
        int          lat;
        logic        e_en, e_cd, e_ed;
        logic [31:0] rd;
        bit          own;
        lat  = (k == 0) ? LAT0 : LAT1;
        e_en = g_valid[k] && (cyc >= g_cycle[k] + 1) && (cyc <= g_cycle[k] + lat);
        e_cd = g_valid[k] && !g_own[k] && (cyc == g_cycle[k] + lat + 1);
        e_ed = g_valid[k] &&  g_own[k] && (cyc == g_cycle[k] + lat + 1);
        if (armed) begin
            chk("mem_en", k, 32'(o_en[k]), 32'(e_en));
            chk("mem_we", k, 32'(o_we[k]), 32'(e_en && g_we[k]));
            if (e_en) begin
                chk("mem_addr", k, o_addr[k], g_addr[k] & 32'hFFFF_FFFC);
                chk("mem_wdata", k, o_wdata[k], g_wdata[k]);
                chk("mem_be", k, 32'(o_be[k]), 32'(g_be[k]));
            end
            chk("cpu_done", k, 32'(o_cd[k]), 32'(e_cd));
            chk("ext_done", k, 32'(o_ed[k]), 32'(e_ed));
            chk("cpu_stall", k, 32'(o_st[k]), 32'(cpu_req && !e_cd));
            chk("cpu_rdata", k, o_crd[k], exp_crd[k]);
            chk("ext_rdata", k, o_erd[k], exp_erd[k]);
        end
        if (k == 0) m_cd0 = e_cd;
        if (!reset) begin
            g_valid[k]  = 1'b0;
            free_at[k]  = cyc + 1;
            last_own[k] = 1'b1;
            exp_crd[k]  = '0;
            exp_erd[k]  = '0;
        end else begin
            // Final access cycle: DM returns the word, already merged for a store
            if (g_valid[k] && cyc == g_cycle[k] + lat) begin
                rd = ref_mem[k][g_addr[k][9:2]];
                if (g_we[k]) begin
                    rd = merge(rd, g_wdata[k], g_be[k]);
                    ref_mem[k][g_addr[k][9:2]] = rd;
                end
                if (g_own[k]) exp_erd[k] = rd;
                else          exp_crd[k] = rd;
            end
            if (cyc >= free_at[k] && (cpu_req || ext_req)) begin
                own = (cpu_req && ext_req) ? !last_own[k] : ext_req;
                g_valid[k]  = 1'b1;
                g_cycle[k]  = cyc;
                free_at[k]  = cyc + lat + 2;
                g_own[k]    = own;
                last_own[k] = own;
                g_we[k]     = own ? ext_we    : cpu_we;
                g_addr[k]   = own ? ext_addr  : cpu_addr;
                g_wdata[k]  = own ? ext_wdata : cpu_wdata;
                g_be[k]     = own ? ext_be    : cpu_be;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sample(k);
            model_step(k);
        end
        if (!reset) armed = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic rand_cpu();
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom() & 32'hFFFF_FC3F;
        cpu_wdata = $urandom(); cpu_be = 4'($urandom());
    endtask

    task automatic rand_ext();
        ext_we = 1'($urandom_range(0, 1)); ext_addr = $urandom() & 32'hFFFF_FC3F;
        ext_wdata = $urandom(); ext_be = 4'($urandom());
    endtask

    int done_cyc[$];
    bit done_own[$];
    int cnt_en0, cnt_en1, cnt_cd0, cnt_cd1, bad;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; armed = 1'b0; m_cd0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            g_valid[k] = 1'b0; g_cycle[k] = 0; free_at[k] = 0; last_own[k] = 1'b1;
            exp_crd[k] = '0; exp_erd[k] = '0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
        end
        reset = 1'b0; mem_init = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
        ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_be = '0;

        // Reset for two cycles, then everything reads zero
        idle(2);
        reset = 1'b1; mem_init = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_en", k, 32'(o_en[k]), 0);
            chk("rst_mem_addr", k, o_addr[k], 0);
            chk("rst_mem_wdata", k, o_wdata[k], 0);
            chk("rst_mem_be", k, 32'(o_be[k]), 0);
            chk("rst_stall", k, 32'(o_st[k]), 0);
            chk("rst_rdata", k, o_crd[k] | o_erd[k], 0);
        end

        // CPU load of a misaligned byte address
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_1006; cpu_wdata = 32'h5555_AAAA; cpu_be = 4'hF;
        tick(); chk("ld_stall_c0", 0, 32'(o_st[0]), 1);
        tick(); chk("ld_en_c1", 0, 32'(o_en[0]), 1); chk("ld_addr_c1", 0, o_addr[0], 32'h0000_1004);
        tick(); chk("ld_en_c2", 0, 32'(o_en[0]), 1); chk("ld_stall_c2", 0, 32'(o_st[0]), 1);
        tick(); chk("ld_done_c3", 0, 32'(o_cd[0]), 1); chk("ld_rdata_c3", 0, o_crd[0], 32'hDEAD_BEEF);
        chk("ld_stall_c3", 0, 32'(o_st[0]), 0); chk("ld_en_c3", 0, 32'(o_en[0]), 0);
        cpu_req = 0;
        idle(4);

        // Fresh reset, then both ports request continuously
        reset = 0; idle(2); reset = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0008; cpu_be = 4'hF;
        ext_req = 1; ext_we = 1; ext_addr = 32'h0000_000C; ext_wdata = 32'hCAFE_0001; ext_be = 4'h3;
        done_cyc.delete(); done_own.delete();
        for (int r = 0; r < 12; r++) begin
            tick();
            if (o_cd[0]) begin done_cyc.push_back(r); done_own.push_back(1'b0); end
            if (o_ed[0]) begin done_cyc.push_back(r); done_own.push_back(1'b1); end
        end
        cpu_req = 0; ext_req = 0;
        chk("rr_count", 0, 32'(done_cyc.size()), 3);
        if (done_cyc.size() == 3) begin
            chk("rr_1st_own", 0, 32'(done_own[0]), 0); chk("rr_1st_cyc", 0, 32'(done_cyc[0]), 3);
            chk("rr_2nd_own", 0, 32'(done_own[1]), 1); chk("rr_2nd_cyc", 0, 32'(done_cyc[1]), 7);
            chk("rr_3rd_own", 0, 32'(done_own[2]), 0); chk("rr_3rd_cyc", 0, 32'(done_cyc[2]), 11);
        end
        idle(8);

        // EXT store in flight when the CPU starts requesting
        ext_req = 1; ext_we = 1; ext_addr = 32'h0000_0200; ext_wdata = 32'h1234_5678; ext_be = 4'hF;
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040; cpu_be = 4'hF;
        tick(); chk("ext_stall_c1", 0, 32'(o_st[0]), 1);
        tick();
        tick(); chk("ext_done_c3", 0, 32'(o_ed[0]), 1); chk("ext_stall_c3", 0, 32'(o_st[0]), 1);
        ext_req = 0;
        tick(); chk("ext_stall_c4", 0, 32'(o_st[0]), 1);
        tick(); chk("cpu_en_c5", 0, 32'(o_en[0]), 1); chk("cpu_addr_c5", 0, o_addr[0], 32'h0000_0040);
        tick();
        tick(); chk("cpu_done_c7", 0, 32'(o_cd[0]), 1);
        cpu_req = 0;
        idle(8);
        chk("ext_store_mem0", 0, dm0[8'h80], 32'h1234_5678);
        chk("ext_store_mem1", 1, dm1[8'h80], 32'h1234_5678);

        // Reset in the second BUSY cycle of a CPU load
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0104; cpu_be = 4'hF;
        tick(); tick();
        reset = 0; tick();
        reset = 1; cpu_req = 0;
        tick(); chk("rst_mid_en", 1, 32'(o_en[1]), 0);
        cnt_cd0 = int'(o_cd[0]); cnt_cd1 = int'(o_cd[1]);
        for (int r = 0; r < 7; r++) begin
            tick(); cnt_cd0 += int'(o_cd[0]); cnt_cd1 += int'(o_cd[1]);
        end
        chk("rst_mid_nodone0", 0, 32'(cnt_cd0), 0);
        chk("rst_mid_nodone1", 1, 32'(cnt_cd1), 0);
        cpu_req = 1;
        for (int r = 0; r < 6; r++) begin
            tick();
            if (r == 5) begin
                chk("post_rst_done", 1, 32'(o_cd[1]), 1);
                chk("post_rst_rdata", 1, o_crd[1], init_word(8'h41));
            end
        end
        cpu_req = 0;
        idle(8);

        // Store with no byte enables still takes a full slot
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_0300; cpu_wdata = 32'hFFFF_FFFF; cpu_be = 4'h0;
        cnt_en0 = 0; cnt_en1 = 0; cnt_cd0 = 0; cnt_cd1 = 0;
        for (int r = 0; r < 6; r++) begin
            tick();
            cnt_en0 += int'(o_en[0]); cnt_en1 += int'(o_en[1]);
            cnt_cd0 += int'(o_cd[0]); cnt_cd1 += int'(o_cd[1]);
            if (o_cd[0]) cpu_req = 0;
        end
        chk("be0_en_cycles0", 0, 32'(cnt_en0), 32'(LAT0));
        chk("be0_en_cycles1", 1, 32'(cnt_en1), 32'(LAT1));
        chk("be0_done0", 0, 32'(cnt_cd0), 1);
        chk("be0_done1", 1, 32'(cnt_cd1), 1);
        idle(4);
        chk("be0_mem0", 0, dm0[8'hC0], init_word(8'hC0));
        chk("be0_mem1", 1, dm1[8'hC0], init_word(8'hC0));

        // Random traffic on both ports, with occasional abandoned requests
        for (int i = 0; i < 600; i++) begin
            if (!cpu_req) begin
                if ($urandom_range(0, 2) == 0) begin cpu_req = 1; rand_cpu(); end
            end else if (m_cd0) begin
                cpu_req = 1'($urandom_range(0, 1)); rand_cpu();
            end else if ($urandom_range(0, 40) == 0) begin
                cpu_req = 0;
            end
            if (!ext_req) begin
                if ($urandom_range(0, 2) == 0) begin ext_req = 1; rand_ext(); end
            end else if (o_ed[0]) begin
                ext_req = 1'($urandom_range(0, 1)); rand_ext();
            end else if ($urandom_range(0, 40) == 0) begin
                ext_req = 0;
            end
            tick();
        end
        cpu_req = 0; ext_req = 0;
        idle(10);

        bad = 0;
        for (int i = 0; i < 256; i++) if (dm0[i] !== ref_mem[0][i]) bad++;
        chk("final_mem", 0, 32'(bad), 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (dm1[i] !== ref_mem[1][i]) bad++;
        chk("final_mem", 1, 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
